// File: rtl/clk_rst_pkg.sv
// Shared FSM state encoding and counter sizing helper for the clock/reset sequencer.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to count from 0 up to and including max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/clk_en_divider.sv
// Per-channel clock-enable divider: one-cycle tick every max(div,1) unpaused cycles.
module clk_en_divider #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    // >= rather than == so that shrinking div mid-period fires at once instead of wrapping.
    always_comb begin
        last = (div == '0) ? '0 : div - DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (hold) begin
            tick <= 1'b0;
        end else if (cnt >= last) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + DIV_W'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_rst_sequencer.sv
// Staged per-domain reset release, per-domain clock-enable ticks and a run-time watchdog.
module clk_rst_sequencer
    import clk_rst_pkg::*;
#(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned HOLD_CYCLES = 5,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*DIV_W-1:0] div_i,
    input  logic                  pause_i,
    output logic [N_CH-1:0]       ch_rst_o,
    output logic [N_CH-1:0]       ch_tick_o,
    output logic                  timeout_o,
    output logic [1:0]            state_o
);

    localparam int unsigned WD_W = cnt_width(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] stage_cnt;
    logic [CNT_W-1:0] stage_nxt;
    logic [WD_W-1:0]  wd_cnt;
    logic             wd_expire;
    logic             done_now;

    // Dividers are cleared on the DONE-entry edge too, so no tick leaks into DONE.
    always_comb begin
        stage_nxt = stage_cnt + CNT_W'(1);
        wd_expire = (state == ST_RUN) && (wd_cnt == WD_W'(TIMEOUT - 1));
        done_now  = (state == ST_DONE) || wd_expire;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            stage_cnt <= '0;
            wd_cnt    <= '0;
            ch_rst_o  <= '1;
            timeout_o <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        ch_rst_o[0] <= 1'b0;
                        state       <= (N_CH == 1) ? ST_RUN : ST_STAGE;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                ST_STAGE: begin
                    stage_cnt <= stage_nxt;
                    for (int unsigned k = 1; k < N_CH; k++) begin
                        if (stage_nxt == CNT_W'(k * STAGE_GAP))
                            ch_rst_o[k] <= 1'b0;
                    end
                    if (stage_nxt == CNT_W'((N_CH - 1) * STAGE_GAP))
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (wd_expire) begin
                        timeout_o <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    timeout_o <= 1'b1;
                    ch_rst_o  <= '0;
                end
            endcase
        end
    end

    assign state_o = state;

    for (genvar k = 0; k < N_CH; k++) begin : g_div
        clk_en_divider #(
            .DIV_W(DIV_W)
        ) u_div (
            .clk   (clk),
            .reset (reset),
            .clr   (ch_rst_o[k] | done_now),
            .hold  (pause_i),
            .div   (div_i[k*DIV_W +: DIV_W]),
            .tick  (ch_tick_o[k])
        );
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench: edge-indexed reference model plus hand-computed anchor checks.
module tb_clk_rst_sequencer;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int H  = 5;
    localparam int G  = 4;
    localparam int T  = 1000;
    localparam int R  = H + (N - 1) * G;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*DW-1:0] div;
    logic            pause;
    logic [N-1:0]    ch_rst;
    logic [N-1:0]    ch_tick;
    logic            timeout;
    logic [1:0]      state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    clk_rst_sequencer #(
        .N_CH(N), .DIV_W(DW), .HOLD_CYCLES(H), .STAGE_GAP(G), .TIMEOUT(T), .CNT_W(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .div_i     (div),
        .pause_i   (pause),
        .ch_rst_o  (ch_rst),
        .ch_tick_o (ch_tick),
        .timeout_o (timeout),
        .state_o   (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: everything derived from n = edges since reset release.
    int           n = 0;
    int           acc [N];
    logic [N-1:0] m_rst;
    logic [N-1:0] m_tick;
    logic         m_to;
    logic [1:0]   m_st;
    bit           mvalid = 0;

    always @(posedge clk) begin
        if (reset) begin
            n = 0;
            for (int k = 0; k < N; k++) acc[k] = 0;
            m_rst  = '1;
            m_tick = '0;
            m_to   = 1'b0;
            m_st   = 2'd0;
            mvalid = 1;
        end else begin
            n++;
            for (int k = 0; k < N; k++) begin
                int rk;
                int d;
                rk = H + k * G;
                d  = int'(div[k*DW +: DW]);
                if (d == 0) d = 1;
                m_rst[k] = (n < rk);
                if (n <= rk || n >= R + T) begin
                    acc[k]    = 0;
                    m_tick[k] = 1'b0;
                end else if (pause) begin
                    m_tick[k] = 1'b0;
                end else begin
                    acc[k]++;
                    m_tick[k] = (acc[k] >= d);
                    if (acc[k] >= d) acc[k] = 0;
                end
            end
            m_to = (n >= R + T);
            m_st = (n < H) ? 2'd0 : (n < R) ? 2'd1 : (n < R + T) ? 2'd2 : 2'd3;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_ch_rst", 32'(ch_rst), 32'(m_rst));
            chk("model_ch_tick", 32'(ch_tick), 32'(m_tick));
            chk("model_timeout", 32'(timeout), 32'(m_to));
            chk("model_state", 32'(state), 32'(m_st));
        end
    end

    task automatic wait_n(input int target);
        for (int i = 0; i < 3000 && n < target; i++) @(negedge clk);
        if (n != target) begin
            total++;
            bad++;
            $display("FAIL wait_n: reached edge %0d expected %0d", n, target);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        div   = {8'd3, 8'd1};
        pause = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        chk("rst_state_rst", 32'(ch_rst), 32'h3);
        chk("rst_state_tick", 32'(ch_tick), 32'h0);
        chk("rst_state_st", 32'(state), 32'd0);

        // Staged release and first ticks.
        wait_n(4);  chk("e4_rst", 32'(ch_rst), 32'h3);
        chk("e4_tick", 32'(ch_tick), 32'h0);
        wait_n(5);  chk("e5_rst", 32'(ch_rst), 32'h2);
        chk("e5_st", 32'(state), 32'd1);
        chk("e5_tick", 32'(ch_tick), 32'h0);
        wait_n(6);  chk("e6_tick0", 32'(ch_tick[0]), 32'h1);
        wait_n(9);  chk("e9_rst", 32'(ch_rst), 32'h0);
        chk("e9_st", 32'(state), 32'd2);
        wait_n(11); chk("e11_tick", 32'(ch_tick), 32'h1);
        wait_n(12); chk("e12_tick", 32'(ch_tick), 32'h3);
        wait_n(15); chk("e15_tick1", 32'(ch_tick[1]), 32'h1);

        // Pause for 7 cycles in RUN; ch1 resumes from frozen phase.
        wait_n(30);
        chk("e30_tick1", 32'(ch_tick[1]), 32'h1);
        pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("pause_tick", 32'(ch_tick), 32'h0);
        end
        pause = 1'b0;
        wait_n(39); chk("e39_tick1", 32'(ch_tick[1]), 32'h0);
        wait_n(40); chk("e40_tick1", 32'(ch_tick[1]), 32'h1);

        // Watchdog expiry and stickiness.
        wait_n(R + T - 1); chk("pre_to", 32'(timeout), 32'h0);
        wait_n(R + T);     chk("to_rise", 32'(timeout), 32'h1);
        chk("to_st", 32'(state), 32'd3);
        chk("to_tick", 32'(ch_tick), 32'h0);
        wait_n(R + T + 50); chk("to_sticky", 32'(timeout), 32'h1);

        // Reset from DONE, divisor change mid-period, div = 0.
        div = {8'd8, 8'd0};
        pulse_reset();
        chk("rd_rst", 32'(ch_rst), 32'h3);
        chk("rd_to", 32'(timeout), 32'h0);
        chk("rd_st", 32'(state), 32'd0);
        wait_n(7);  chk("div0_tick0", 32'(ch_tick[0]), 32'h1);
        pulse_reset();
        chk("rs_rst", 32'(ch_rst), 32'h3);
        chk("rs_st", 32'(state), 32'd0);
        wait_n(5);  chk("rs_e5_rst", 32'(ch_rst), 32'h2);
        wait_n(9);  chk("rs_e9_st", 32'(state), 32'd2);
        wait_n(14);
        chk("pre_shrink", 32'(ch_tick[1]), 32'h0);
        div[DW +: DW] = 8'd2;
        wait_n(15); chk("shrink_e15", 32'(ch_tick[1]), 32'h1);
        wait_n(16); chk("shrink_e16", 32'(ch_tick[1]), 32'h0);
        wait_n(17); chk("shrink_e17", 32'(ch_tick[1]), 32'h1);

        // Randomised divisors and pause, through DONE, then reset again.
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 7) == 0) div[k*DW +: DW] = 8'($urandom_range(0, 6));
            pause = ($urandom_range(0, 3) == 0);
        end
        pulse_reset();
        chk("rr_st", 32'(state), 32'd0);
        chk("rr_to", 32'(timeout), 32'h0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            div   = 16'($urandom_range(0, 16'hffff)) & 16'h0707;
            pause = ($urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
